// File: rtl/led_blink_scheduler.sv
// Round-robin scheduler that shares one status LED among N_REQ requesters,
// playing each granted blink code as ON/OFF pulses followed by a dark gap.
module led_blink_scheduler #(
    parameter int unsigned TICK_DIV  = 2_500_000,
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned CNT_W     = 4,
    parameter int unsigned ON_TICKS  = 4,
    parameter int unsigned OFF_TICKS = 4,
    parameter int unsigned GAP_TICKS = 20
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*CNT_W-1:0]   code,
    output logic [N_REQ-1:0]         grant,
    output logic                     done,
    output logic                     busy,
    output logic                     led
);

    localparam int unsigned IDX_W   = $clog2(N_REQ);
    localparam int unsigned PS_W    = $clog2(TICK_DIV) + 1;
    localparam int unsigned PH_MAX0 = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int unsigned PH_MAX  = (PH_MAX0 > GAP_TICKS) ? PH_MAX0 : GAP_TICKS;
    localparam int unsigned PH_W    = $clog2(PH_MAX) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_OFF  = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    state_t             r_state;
    logic [PS_W-1:0]    r_ps;
    logic [PH_W-1:0]    r_phase;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic [CNT_W-1:0]   r_remaining;

    logic               w_tick;
    logic               w_found;
    logic [IDX_W-1:0]   w_winner;
    logic [IDX_W:0]     w_sum;
    logic [CNT_W-1:0]   w_code;
    logic [N_REQ-1:0]   w_onehot;

    assign w_tick = (r_ps == PS_W'(TICK_DIV - 1));

    // Round-robin search starting just after the last winner, with wrap-around.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_sum    = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            w_sum = {1'b0, r_rr_ptr} + (IDX_W+1)'(k);
            if (w_sum >= (IDX_W+1)'(N_REQ))
                w_sum = w_sum - (IDX_W+1)'(N_REQ);
            if (!w_found && req[w_sum[IDX_W-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_sum[IDX_W-1:0];
            end
        end
    end

    // Winner's code field and one-hot grant vector.
    always_comb begin
        w_code   = '0;
        w_onehot = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (w_winner == IDX_W'(i)) begin
                w_code      = code[i*CNT_W +: CNT_W];
                w_onehot[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ps        <= '0;
            r_phase     <= '0;
            r_rr_ptr    <= IDX_W'(N_REQ - 1);
            r_remaining <= '0;
            grant       <= '0;
            done        <= 1'b0;
            busy        <= 1'b0;
            led         <= 1'b0;
        end else begin
            done <= 1'b0;
            if (r_state != S_IDLE)
                r_ps <= w_tick ? '0 : r_ps + PS_W'(1);

            case (r_state)
                S_IDLE: begin
                    grant <= '0;
                    if (w_found) begin
                        grant    <= w_onehot;
                        r_rr_ptr <= w_winner;
                        r_ps     <= '0;
                        r_phase  <= '0;
                        // A zero code completes in the grant cycle itself.
                        if (w_code == '0) begin
                            done <= 1'b1;
                        end else begin
                            r_state     <= S_ON;
                            led         <= 1'b1;
                            busy        <= 1'b1;
                            r_remaining <= w_code - CNT_W'(1);
                        end
                    end
                end
                S_ON: begin
                    if (w_tick) begin
                        if (r_phase == PH_W'(ON_TICKS - 1)) begin
                            r_state <= S_OFF;
                            led     <= 1'b0;
                            r_phase <= '0;
                        end else begin
                            r_phase <= r_phase + PH_W'(1);
                        end
                    end
                end
                S_OFF: begin
                    if (w_tick) begin
                        if (r_phase == PH_W'(OFF_TICKS - 1)) begin
                            r_phase <= '0;
                            if (r_remaining != '0) begin
                                r_state     <= S_ON;
                                led         <= 1'b1;
                                r_remaining <= r_remaining - CNT_W'(1);
                            end else begin
                                r_state <= S_GAP;
                            end
                        end else begin
                            r_phase <= r_phase + PH_W'(1);
                        end
                    end
                end
                S_GAP: begin
                    if (w_tick) begin
                        if (r_phase == PH_W'(GAP_TICKS - 1)) begin
                            r_state <= S_IDLE;
                            r_phase <= '0;
                            grant   <= '0;
                            done    <= 1'b1;
                            busy    <= 1'b0;
                        end else begin
                            r_phase <= r_phase + PH_W'(1);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_led_blink_scheduler.sv
// Directed bench for led_blink_scheduler with short timing parameters:
// one blink period is 16 cycles, the gap is 12 cycles.
module tb_led_blink_scheduler;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned CNT_W = 4;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [N_REQ-1:0]       req;
    logic [N_REQ*CNT_W-1:0] code;
    logic [N_REQ-1:0]       grant;
    logic                   done;
    logic                   busy;
    logic                   led;

    int n_chk  = 0;
    int n_pass = 0;

    led_blink_scheduler #(
        .TICK_DIV (4),
        .N_REQ    (N_REQ),
        .CNT_W    (CNT_W),
        .ON_TICKS (2),
        .OFF_TICKS(2),
        .GAP_TICKS(3)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .code (code),
        .grant(grant),
        .done (done),
        .busy (busy),
        .led  (led)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    logic [N_REQ-1:0] rr_exp [5];
    int rises;
    int bad;
    logic prev;

    initial begin
        rst  = 1'b1;
        req  = '0;
        code = '0;
        step(3);
        rst = 1'b0;
        chk("reset_led",   32'(led),   32'd0);
        chk("reset_grant", 32'(grant), 32'd0);
        chk("reset_busy",  32'(busy),  32'd0);
        chk("reset_done",  32'(done),  32'd0);

        // Single request, code 2 on requester 0
        code = 16'h0002;
        req  = 4'b0001;
        step(1);
        chk("single_grant", 32'(grant), 32'h1);
        chk("single_led_on", 32'(led), 32'd1);
        chk("single_busy", 32'(busy), 32'd1);
        req = '0;
        step(7);
        chk("single_led_g7", 32'(led), 32'd1);
        step(1);
        chk("single_led_g8", 32'(led), 32'd0);
        step(8);
        chk("single_led_g16", 32'(led), 32'd1);
        step(8);
        chk("single_led_g24", 32'(led), 32'd0);
        step(19);
        chk("single_nodone_g43", 32'(done), 32'd0);
        chk("single_grant_g43", 32'(grant), 32'h1);
        step(1);
        chk("single_done_g44", 32'(done), 32'd1);
        chk("single_grant_off", 32'(grant), 32'd0);
        chk("single_busy_off", 32'(busy), 32'd0);
        step(1);
        chk("single_done_pulse", 32'(done), 32'd0);

        // All four requesting, code 1 each; last winner was requester 0
        rr_exp[0] = 4'b0010;
        rr_exp[1] = 4'b0100;
        rr_exp[2] = 4'b1000;
        rr_exp[3] = 4'b0001;
        rr_exp[4] = 4'b0010;
        code = 16'h1111;
        req  = 4'b1111;
        step(1);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("rr_grant_%0d", i), 32'(grant), 32'(rr_exp[i]));
            if (i == 4) req = '0;
            step(27);
            chk($sformatf("rr_nodone_%0d", i), 32'(done), 32'd0);
            step(1);
            chk($sformatf("rr_done_%0d", i), 32'(done), 32'd1);
            chk($sformatf("rr_grant_clr_%0d", i), 32'(grant), 32'd0);
            step(1);
        end
        chk("rr_idle_after", 32'(grant), 32'd0);

        // Zero code on requester 1
        code = 16'h0000;
        req  = 4'b0010;
        step(1);
        chk("zero_grant", 32'(grant), 32'h2);
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_busy", 32'(busy), 32'd0);
        chk("zero_led", 32'(led), 32'd0);
        req = '0;
        step(1);
        chk("zero_grant_clr", 32'(grant), 32'd0);
        chk("zero_done_clr", 32'(done), 32'd0);

        // Requester 2 code 3; req dropped and code changed mid-service
        code = 16'h0300;
        req  = 4'b0100;
        step(1);
        chk("mid_grant", 32'(grant), 32'h4);
        req  = '0;
        code = 16'h0700;
        rises = led ? 1 : 0;
        prev  = led;
        bad   = 0;
        for (int k = 1; k < 60; k++) begin
            step(1);
            if (led && !prev) rises++;
            if (led !== (((k % 16) < 8) && (k < 48))) bad++;
            prev = led;
            if (done) bad++;
        end
        chk("mid_pattern", 32'(bad), 32'd0);
        chk("mid_rises", 32'(rises), 32'd3);
        step(1);
        chk("mid_done_g60", 32'(done), 32'd1);

        // Maximum code on requester 3
        code = 16'hF000;
        req  = 4'b1000;
        step(1);
        chk("max_grant", 32'(grant), 32'h8);
        req   = '0;
        rises = led ? 1 : 0;
        prev  = led;
        bad   = 0;
        for (int k = 1; k < 252; k++) begin
            step(1);
            if (led && !prev) begin
                rises++;
                if ((k % 16) != 0) bad++;
            end
            if (led !== (((k % 16) < 8) && (k < 240))) bad++;
            prev = led;
            if (done) bad++;
        end
        chk("max_pattern", 32'(bad), 32'd0);
        chk("max_rises", 32'(rises), 32'd15);
        step(1);
        chk("max_done_g252", 32'(done), 32'd1);

        // Reset in the middle of an ON phase, then priority restarts at 0
        code = 16'h0100;
        req  = 4'b0100;
        step(1);
        chk("rst_mid_grant", 32'(grant), 32'h4);
        step(3);
        chk("rst_mid_led_on", 32'(led), 32'd1);
        rst = 1'b1;
        req = '0;
        step(3);
        rst = 1'b0;
        chk("rst_mid_led", 32'(led), 32'd0);
        chk("rst_mid_grant_clr", 32'(grant), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_done", 32'(done), 32'd0);
        code = 16'h1001;
        req  = 4'b1001;
        step(1);
        chk("rst_prio_grant", 32'(grant), 32'h1);
        req = '0;
        step(28);
        chk("rst_prio_done", 32'(done), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
